// File: rtl/rr_stage_arbiter.sv
// Round-robin arbiter feeding one shared valid/ready output register, with same-source
// burst hold of up to MAX_BURST beats and a source tag on every registered beat.
module rr_stage_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           i_valid,
  input  logic [N_REQ*DATA_W-1:0]    i_data,
  output logic [N_REQ-1:0]           o_ready,
  output logic                       o_valid,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(N_REQ)-1:0]   o_src,
  input  logic                       i_ready
);

  localparam int unsigned SRC_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StArb, StBurst} state_e;

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic [SRC_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 o_valid_q, o_valid_d;
  logic [DATA_W-1:0]    o_data_q, o_data_d;
  logic [SRC_W-1:0]     o_src_q, o_src_d;

  logic                 load_en;
  logic                 owner_valid;
  logic                 burst_cont;
  logic [SRC_W-1:0]     scan_start;
  logic                 scan_found;
  logic [SRC_W-1:0]     scan_idx;
  logic                 grant_vld;
  logic [SRC_W-1:0]     grant_idx;

  // N_REQ need not be a power of two, so wrap explicitly instead of relying on overflow.
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    if (idx == SRC_W'(N_REQ - 1)) begin
      return '0;
    end
    return idx + SRC_W'(1);
  endfunction

  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    return SRC_W'(sum);
  endfunction

  assign load_en     = !o_valid_q || i_ready;
  assign owner_valid = i_valid[owner_q];
  assign burst_cont  = (state_q == StBurst) && owner_valid;
  assign scan_start  = (state_q == StBurst) ? next_idx(owner_q) : ptr_q;

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!scan_found && i_valid[wrap_add(scan_start, i)]) begin
        scan_found = 1'b1;
        scan_idx   = wrap_add(scan_start, i);
      end
    end
  end

  always_comb begin
    if (burst_cont) begin
      grant_vld = 1'b1;
      grant_idx = owner_q;
    end else begin
      grant_vld = scan_found;
      grant_idx = scan_idx;
    end
  end

  // Grant is withheld entirely during backpressure and while reset is asserted.
  always_comb begin
    o_ready = '0;
    if (reset && load_en && grant_vld) begin
      o_ready = N_REQ'(1) << grant_idx;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_src_d   = o_src_q;

    if (load_en) begin
      o_valid_d = grant_vld;
      if (grant_vld) begin
        o_data_d = i_data[grant_idx*DATA_W +: DATA_W];
        o_src_d  = grant_idx;
      end

      if (burst_cont) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (32'(cnt_q) + 1 == MAX_BURST) begin
          state_d = StArb;
          ptr_d   = next_idx(owner_q);
        end
      end else begin
        // A burst whose owner dropped out hands the pointer past the owner first.
        if (state_q == StBurst) begin
          state_d = StArb;
          ptr_d   = next_idx(owner_q);
        end
        if (grant_vld) begin
          if (MAX_BURST == 1) begin
            state_d = StArb;
            ptr_d   = next_idx(grant_idx);
          end else begin
            state_d = StBurst;
            owner_d = grant_idx;
            cnt_d   = CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StArb;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_src_q   <= o_src_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_src   = o_src_q;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(o_ready));
  a_stall_no_grant : assert property (@(posedge clk) disable iff (!reset)
                                      (o_valid && !i_ready) |-> (o_ready == '0));

endmodule

// File: tb/tb_rr_stage_arbiter.sv
// Bench for rr_stage_arbiter: two instances (MAX_BURST=2 and 1) share stimulus and are
// compared against a behavioural model of grants, bursts and the output register.
module tb_rr_stage_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    i_valid;
  logic [N*8-1:0]  i_data;
  logic            i_ready;

  logic [N-1:0]    o_ready_w [2];
  logic            o_valid_w [2];
  logic [7:0]      o_data_w  [2];
  logic [1:0]      o_src_w   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: 0 -> MAX_BURST=2, 1 -> MAX_BURST=1.
  int mb [2] = '{2, 1};
  int m_valid [2];
  int m_data  [2];
  int m_src   [2];
  int m_ptr   [2];
  int m_inb   [2];
  int m_own   [2];
  int m_len   [2];

  rr_stage_arbiter #(.N_REQ(N), .DATA_W(8), .MAX_BURST(2)) u_b2 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready_w[0]),
    .o_valid(o_valid_w[0]), .o_data(o_data_w[0]), .o_src(o_src_w[0]), .i_ready(i_ready)
  );

  rr_stage_arbiter #(.N_REQ(N), .DATA_W(8), .MAX_BURST(1)) u_b1 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready_w[1]),
    .o_valid(o_valid_w[1]), .o_data(o_data_w[1]), .o_src(o_src_w[1]), .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_data[m] = 0; m_src[m] = 0;
      m_ptr[m] = 0; m_inb[m] = 0; m_own[m] = 0; m_len[m] = 0;
    end
  endtask

  // Which requester the instance grants right now, or -1.
  function automatic int model_grant(int m);
    int start;
    if (!reset) return -1;
    if (m_valid[m] != 0 && !i_ready) return -1;
    if (m_inb[m] != 0 && i_valid[m_own[m]]) return m_own[m];
    start = (m_inb[m] != 0) ? (m_own[m] + 1) % N : m_ptr[m];
    for (int i = 0; i < N; i++) begin
      if (i_valid[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(int m, int g);
    if (m_valid[m] != 0 && !i_ready) return;
    if (m_inb[m] != 0 && !i_valid[m_own[m]]) begin
      m_ptr[m] = (m_own[m] + 1) % N;
      m_inb[m] = 0;
    end
    if (g < 0) begin
      m_valid[m] = 0;
    end else begin
      if (m_inb[m] != 0) begin
        m_len[m]++;
      end else begin
        m_inb[m] = 1; m_own[m] = g; m_len[m] = 1;
      end
      if (m_len[m] == mb[m]) begin
        m_inb[m] = 0;
        m_ptr[m] = (g + 1) % N;
      end
      m_valid[m] = 1;
      m_data[m]  = int'(i_data[g*8 +: 8]);
      m_src[m]   = g;
    end
  endtask

  // Advance one clock; returns each instance's grant for that edge.
  task automatic tick(output int g0, output int g1);
    g0 = model_grant(0);
    g1 = model_grant(1);
    @(posedge clk);
    if (reset) begin
      model_edge(0, g0);
      model_edge(1, g1);
    end
    #1;
  endtask

  task automatic set_all_valid();
    i_valid = 4'hF;
    for (int k = 0; k < N; k++) i_data[k*8 +: 8] = 8'(8'h10 + k);
  endtask

  task automatic do_reset();
    int g0, g1;
    reset = 1'b0;
    i_valid = '0;
    i_ready = 1'b1;
    model_reset();
    tick(g0, g1);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int g0, g1;
    reset = 1'b0;
    i_ready = 1'b1;
    set_all_valid();
    model_reset();
    tick(g0, g1);
    tick(g0, g1);
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (o_ready_w[m] !== 4'b0000 || o_valid_w[m] !== 1'b0 || o_src_w[m] !== 2'd0) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: ready=%b valid=%b src=%0d, want 0000 0 0", m,
                 o_ready_w[m], o_valid_w[m], o_src_w[m]);
      end
    end
    reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (o_ready_w[m] !== 4'b0001) begin
        n_errors++;
        $display("FAIL reset_release_ready[%0d]: got %b want 0001", m, o_ready_w[m]);
      end
    end
    tick(g0, g1);
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (o_valid_w[m] !== 1'b1 || o_src_w[m] !== 2'd0 || o_data_w[m] !== 8'h10) begin
        n_errors++;
        $display("FAIL reset_first_grant[%0d]: valid=%b src=%0d data=%h, want 1 0 10", m,
                 o_valid_w[m], o_src_w[m], o_data_w[m]);
      end
    end
  endtask

  task automatic test_round_robin();
    int g0, g1;
    logic [7:0] exp_b1 [5];
    logic [7:0] exp_b2 [5];
    exp_b1 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_b2 = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12};
    do_reset();
    set_all_valid();
    for (int c = 0; c < 5; c++) begin
      tick(g0, g1);
      n_checks++;
      if (o_valid_w[1] !== 1'b1 || o_data_w[1] !== exp_b1[c]) begin
        n_errors++;
        $display("FAIL rr_mb1 cycle %0d: valid=%b data=%h want 1 %h", c, o_valid_w[1],
                 o_data_w[1], exp_b1[c]);
      end
      n_checks++;
      if (o_valid_w[0] !== 1'b1 || o_data_w[0] !== exp_b2[c]) begin
        n_errors++;
        $display("FAIL rr_mb2 cycle %0d: valid=%b data=%h want 1 %h", c, o_valid_w[0],
                 o_data_w[0], exp_b2[c]);
      end
    end
  endtask

  task automatic test_burst();
    int g0, g1;
    logic [1:0] exp_src [6];
    logic [3:0] exp_rdy [6];
    exp_src = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    exp_rdy = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    do_reset();
    i_valid = 4'b0011;
    i_data  = 32'h0000_2120;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (o_ready_w[0] !== exp_rdy[c]) begin
        n_errors++;
        $display("FAIL burst_ready cycle %0d: got %b want %b", c, o_ready_w[0], exp_rdy[c]);
      end
      tick(g0, g1);
      n_checks++;
      if (o_src_w[0] !== exp_src[c]) begin
        n_errors++;
        $display("FAIL burst_src cycle %0d: got %0d want %0d", c, o_src_w[0], exp_src[c]);
      end
    end
  endtask

  task automatic test_early_end();
    int g0, g1;
    do_reset();
    i_data  = 32'h3322_1100;
    i_valid = 4'b0100;
    tick(g0, g1);
    n_checks++;
    if (o_src_w[0] !== 2'd2 || o_data_w[0] !== 8'h22) begin
      n_errors++;
      $display("FAIL early_first: src=%0d data=%h want 2 22", o_src_w[0], o_data_w[0]);
    end
    i_valid = 4'b1000;
    #1;
    n_checks++;
    if (o_ready_w[0] !== 4'b1000) begin
      n_errors++;
      $display("FAIL early_handoff_ready: got %b want 1000", o_ready_w[0]);
    end
    tick(g0, g1);
    n_checks++;
    if (o_src_w[0] !== 2'd3 || o_data_w[0] !== 8'h33) begin
      n_errors++;
      $display("FAIL early_second: src=%0d data=%h want 3 33", o_src_w[0], o_data_w[0]);
    end
    tick(g0, g1);
    i_valid = 4'hF;
    #1;
    // Owner 3 finished its burst, so the pointer wraps to 0.
    n_checks++;
    if (o_ready_w[0] !== 4'b0001) begin
      n_errors++;
      $display("FAIL early_wrap_ready: got %b want 0001", o_ready_w[0]);
    end
  endtask

  task automatic test_backpressure();
    int g0, g1;
    do_reset();
    set_all_valid();
    tick(g0, g1);
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (o_ready_w[m] !== 4'b0000 || o_valid_w[m] !== 1'b1 || o_data_w[m] !== 8'h10 ||
            o_src_w[m] !== 2'd0) begin
          n_errors++;
          $display("FAIL stall[%0d] cycle %0d: ready=%b valid=%b data=%h src=%0d", m, c,
                   o_ready_w[m], o_valid_w[m], o_data_w[m], o_src_w[m]);
        end
      end
      tick(g0, g1);
    end
    i_ready = 1'b1;
    #1;
    n_checks++;
    if (o_ready_w[0] !== 4'b0001 || o_ready_w[1] !== 4'b0010) begin
      n_errors++;
      $display("FAIL stall_resume_ready: got %b %b want 0001 0010", o_ready_w[0],
               o_ready_w[1]);
    end
    tick(g0, g1);
    n_checks++;
    if (o_data_w[0] !== 8'h10 || o_data_w[1] !== 8'h11) begin
      n_errors++;
      $display("FAIL stall_resume_data: got %h %h want 10 11", o_data_w[0], o_data_w[1]);
    end
  endtask

  task automatic test_mid_reset();
    int g0, g1;
    do_reset();
    set_all_valid();
    tick(g0, g1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (o_valid_w[m] !== 1'b0 || o_ready_w[m] !== 4'b0000) begin
        n_errors++;
        $display("FAIL mid_reset[%0d]: valid=%b ready=%b want 0 0000", m, o_valid_w[m],
                 o_ready_w[m]);
      end
    end
    tick(g0, g1);
    reset = 1'b1;
    tick(g0, g1);
    n_checks++;
    if (o_src_w[0] !== 2'd0 || o_valid_w[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_regrant: valid=%b src=%0d want 1 0", o_valid_w[0], o_src_w[0]);
    end
  endtask

  task automatic test_random();
    int g0, g1, g;
    logic [N-1:0] got [2];
    logic [N-1:0] exp_rdy;
    do_reset();
    got[0] = '1;
    got[1] = '1;
    for (int c = 0; c < 600; c++) begin
      // A valid request stays put until both instances have taken it.
      for (int k = 0; k < N; k++) begin
        if (!i_valid[k] || (got[0][k] && got[1][k])) begin
          i_valid[k] = ($urandom_range(0, 3) != 0);
          i_data[k*8 +: 8] = 8'($urandom);
          got[0][k] = 1'b0;
          got[1][k] = 1'b0;
        end
      end
      i_ready = ($urandom_range(0, 9) < 7);
      #1;
      for (int m = 0; m < 2; m++) begin
        g = model_grant(m);
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        n_checks++;
        if (o_ready_w[m] !== exp_rdy || o_valid_w[m] !== (m_valid[m] != 0)) begin
          n_errors++;
          $display("FAIL rand_ctrl[%0d] cycle %0d: ready=%b valid=%b want %b %0d", m, c,
                   o_ready_w[m], o_valid_w[m], exp_rdy, m_valid[m]);
        end
        if (m_valid[m] != 0) begin
          n_checks++;
          if (o_data_w[m] !== 8'(m_data[m]) || o_src_w[m] !== 2'(m_src[m])) begin
            n_errors++;
            $display("FAIL rand_beat[%0d] cycle %0d: data=%h src=%0d want %h %0d", m, c,
                     o_data_w[m], o_src_w[m], 8'(m_data[m]), m_src[m]);
          end
        end
      end
      tick(g0, g1);
      if (g0 >= 0) got[0][g0] = 1'b1;
      if (g1 >= 0) got[1][g1] = 1'b1;
    end
  endtask

  initial begin
    reset   = 1'b0;
    i_valid = '0;
    i_data  = '0;
    i_ready = 1'b1;
    #1;
    test_reset();
    test_round_robin();
    test_burst();
    test_early_end();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
